rs75_encoder: RTL
=================

# rs75_encoder

Streaming systematic Reed-Solomon RS(7,5) encoder over GF(2^3), the transmit-side counterpart to the syndrome-based decoder datapath. It accepts 5 message symbols one per handshake and emits the 7-symbol codeword one per handshake: the 5 message symbols unchanged, then 2 parity symbols. It sits between the message source and the channel or packer. Every emitted codeword must produce all-zero syndromes s1 and s2 in the decoder's syndrome stage.

## Interface
Parameters:
- No Verilog parameters.
- `SYMBOL_WIDTH`, default 3 (global macro): symbol width.
- `N`, default 7 (global macro): codeword length. Message length K = `N` − 2 = 5.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  message symbol valid.
- in_ready  out  1  encoder accepts a message symbol this cycle.
- in_sym  in  `SYMBOL_WIDTH`  message symbol. The first symbol accepted is the highest-degree coefficient (x^6).
- out_valid  out  1  codeword symbol valid.
- out_ready  in  1  downstream accepts.
- out_sym  out  `SYMBOL_WIDTH`  codeword symbol, highest degree first.
- out_last  out  1  high with the 7th (final parity) symbol.
- chk_err  out  1  present only with RS75_ENC_SELFCHECK_EN (see Configuration).

## Operation
- Field: primitive polynomial x^3+x+1, α = 3'b010. Power table: α^0..α^6 = 1, 2, 4, 3, 6, 7, 5.
- Generator polynomial: g(x) = (x−α)(x−α^2) = x^2 + 6x + 3, so g1 = 3'd6 and g0 = 3'd3. These are constant multipliers (XOR networks); no table RAM.
- Parity LFSR registers r1 and r0. On each accepted message symbol m:
  - fb = m ^ r1
  - r1 ← r0 ^ g1·fb
  - r0 ← g0·fb
- FSM states:
  - MSG: cnt 0..4. in_ready = (!out_valid || out_ready). Each accepted symbol is copied to out_sym and updates the LFSR. Leaving cnt = 4 goes to PAR1.
  - PAR1: in_ready = 0. When the output slot is free, load out_sym = r1, then go to PAR2.
  - PAR2: in_ready = 0. When the output slot is free, load out_sym = r0 with out_last = 1, clear r1/r0/cnt, then go to MSG.
- Output stage: one register. out_valid stays set until out_valid && out_ready. out_sym and out_last hold stable while out_valid && !out_ready.
- Back-to-back codewords: the first message symbol of the next codeword may be accepted in the cycle after the PAR2 load.

## Timing
- Reset (asynchronous assert, synchronous release): state = MSG, cnt = 0, r1 = r0 = 0, out_valid = 0, out_sym = 0, out_last = 0, chk_err = 0, in_ready = 1.
- Latency: in_sym accepted on edge t appears on out_sym from edge t (visible cycle t+1).
- Parity: r1 is loaded on the first free edge after the 5th message symbol is accepted; r0 is loaded on the next free edge.
- Throughput: 7 output cycles per 5 input symbols. With out_ready held at 1, in_ready is low for exactly 2 cycles per codeword.
- Simultaneous pop and load: out_valid && out_ready on the same edge as a new load keeps out_valid = 1, with no bubble.
- in_valid while in_ready = 0: ignored. The input is not sampled.
- rst_n asserted mid-codeword: the partial codeword is discarded and the block returns to reset values. There is no partial flush.

## Configuration
- RS75_ENC_SELFCHECK_EN:
  - Defined: adds the chk_err port and two syndrome accumulators S1 and S2. On each output handshake, Si ← Si·α^i ^ out_sym (Horner evaluation).
  - At the out_last handshake, chk_err is registered as |(S1|S2) computed including that symbol. chk_err is sticky until reset. The accumulators clear after out_last.
  - Undefined: no port and no accumulator logic.

## Test plan
- Message 1,0,0,0,0 with out_ready = 1 -> output 1,0,0,0,0,6,2; out_last high only on the 2; chk_err = 0.
- Message 0,0,0,0,1 -> output 0,0,0,0,1,6,3.
- Message all zeros -> output seven zeros. Then random back-to-back messages, each codeword checked against the syndrome model (s1 = s2 = 0).
- out_ready toggled randomly (including held low for 5 cycles during PAR1) -> out_sym/out_last stable while stalled, no symbol lost or duplicated, in_ready = 0 in PAR1/PAR2.
- rst_n pulsed low after 3 message symbols -> all outputs return to reset values immediately. Next message 0,0,0,0,1 -> 0,0,0,0,1,6,3 (no stale LFSR state).
- With RS75_ENC_SELFCHECK_EN, force r0 bit 0 inverted via the bench -> chk_err = 1 after out_last and held until reset.

Source files
------------

// File: rtl/rs75_encoder.sv
// rs75_encoder
// Streaming systematic Reed-Solomon RS(7,5) encoder over GF(2^3), field
// polynomial x^3+x+1, generator g(x) = x^2 + 6x + 3. Five message symbols
// are accepted one per handshake and forwarded unchanged, followed by the
// two parity symbols r1 and r0. Every codeword has zero syndromes at
// alpha and alpha^2.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   message symbol valid
//   in_ready   out  a message symbol is accepted this cycle
//   in_sym     in   message symbol, highest-degree coefficient first
//   out_valid  out  codeword symbol valid
//   out_ready  in   downstream accepts the current symbol
//   out_sym    out  codeword symbol, highest degree first
//   out_last   out  high with the final parity symbol
//   chk_err    out  sticky syndrome-check error (RS75_ENC_SELFCHECK_EN only)
//
// Configuration:
//   RS75_ENC_SELFCHECK_EN  adds the chk_err port and Horner syndrome
//                          accumulators over the emitted stream.
//   SYMBOL_WIDTH / N       global macros, default 3 / 7.

`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 3
`endif
`ifndef N
`define N 7
`endif

module rs75_encoder (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [`SYMBOL_WIDTH-1:0] in_sym,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [`SYMBOL_WIDTH-1:0] out_sym,
    output logic                     out_last
`ifdef RS75_ENC_SELFCHECK_EN
    ,
    output logic                     chk_err
`endif
);

    localparam int SW = `SYMBOL_WIDTH;
    localparam int K  = `N - 2;

    typedef enum logic [1:0] {
        MSG  = 2'd0,
        PAR1 = 2'd1,
        PAR2 = 2'd2
    } state_t;

    // Multiply by alpha: shift up one degree and fold x^3 back as x+1.
    function automatic logic [SW-1:0] gfMulAlpha(input logic [SW-1:0] a);
        return {a[1], a[0] ^ a[2], a[2]};
    endfunction

    // Constant multipliers built from the alpha step; pure XOR networks.
    function automatic logic [SW-1:0] gfMul3(input logic [SW-1:0] a);
        return gfMulAlpha(a) ^ a;
    endfunction

    function automatic logic [SW-1:0] gfMul4(input logic [SW-1:0] a);
        return gfMulAlpha(gfMulAlpha(a));
    endfunction

    function automatic logic [SW-1:0] gfMul6(input logic [SW-1:0] a);
        return gfMul4(a) ^ gfMulAlpha(a);
    endfunction

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [SW-1:0]   r1_q;
    logic [SW-1:0]   r0_q;
    logic [SW-1:0]   r1_d;
    logic [SW-1:0]   r0_d;
    logic [SW-1:0]   fb;
    logic [SW-1:0]   out_sym_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            slotFree;
    logic            inFire;

    // The single output register may be reloaded when it is empty or is
    // being drained on this same edge, which avoids a bubble.
    assign slotFree = !out_valid_q || out_ready;
    assign in_ready = (state_q == MSG) && slotFree;
    assign inFire   = in_valid && in_ready;

    // Parity LFSR next state: division of m(x)*x^2 by g(x).
    assign fb   = in_sym ^ r1_q;
    assign r1_d = r0_q ^ gfMul6(fb);
    assign r0_d = gfMul3(fb);

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MSG;
            cnt_q       <= 3'd0;
            r1_q        <= '0;
            r0_q        <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                MSG: begin
                    if (inFire) begin
                        out_sym_q   <= in_sym;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        r1_q        <= r1_d;
                        r0_q        <= r0_d;
                        if (cnt_q == 3'(K - 1)) begin
                            cnt_q   <= 3'd0;
                            state_q <= PAR1;
                        end else begin
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                PAR1: begin
                    if (slotFree) begin
                        out_sym_q   <= r1_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= PAR2;
                    end
                end
                PAR2: begin
                    // Clearing the LFSR here lets the next codeword start
                    // on the following edge.
                    if (slotFree) begin
                        out_sym_q   <= r0_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        r1_q        <= '0;
                        r0_q        <= '0;
                        cnt_q       <= 3'd0;
                        state_q     <= MSG;
                    end
                end
                default: begin
                    state_q <= MSG;
                end
            endcase
        end
    end

`ifdef RS75_ENC_SELFCHECK_EN
    logic [SW-1:0] s1_q;
    logic [SW-1:0] s2_q;
    logic [SW-1:0] s1Next;
    logic [SW-1:0] s2Next;
    logic          chk_err_q;
    logic          outFire;

    // Horner evaluation of the emitted codeword at alpha and alpha^2.
    assign outFire = out_valid_q && out_ready;
    assign s1Next  = gfMulAlpha(s1_q) ^ out_sym_q;
    assign s2Next  = gfMul4(s2_q) ^ out_sym_q;
    assign chk_err = chk_err_q;

    // The error flag folds in the final symbol and stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            chk_err_q <= 1'b0;
        end else if (outFire) begin
            if (out_last_q) begin
                chk_err_q <= chk_err_q | (|(s1Next | s2Next));
                s1_q      <= '0;
                s2_q      <= '0;
            end else begin
                s1_q      <= s1Next;
                s2_q      <= s2Next;
            end
        end
    end
`endif

endmodule
